// File: rtl/semafor_multi_if.sv
// Lamp/strobe bundle between the track-sensor side and semafor_multi.
// master drives train/divider and watches the lamps; slave is the controller.
interface semafor_multi_if #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 2
);
    logic [CHANNELS-1:0] train;
    logic [DIV_W-1:0]    divider;
    logic [CHANNELS-1:0] red;
    logic [CHANNELS-1:0] yellow;
    logic [CHANNELS-1:0] green;
    logic [CHANNELS-1:0] busy;
    logic                all_green;

    modport master (
        output train, divider,
        input  red, yellow, green, busy, all_green
    );

    modport slave (
        input  train, divider,
        output red, yellow, green, busy, all_green
    );
endinterface

// File: rtl/semafor_multi.sv
// Multi-channel crossing semaphore: per-channel RED->YELLOW->GREEN with train preemption.
// Optional SEMAFOR_BLINK_EN makes yellow blink with BLINK_HALF-cycle half-period.
module semafor_lane #(
    parameter int DIV_W      = 2,
    parameter int CNT_W      = 8,
    parameter int RED_BASE   = 16,
    parameter int YEL_BASE   = 8,
    parameter int BLINK_HALF = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_train,
    input  logic [DIV_W-1:0] i_divider,
    output logic             o_red,
    output logic             o_yellow,
    output logic             o_green,
    output logic             o_busy
);
    typedef enum logic [1:0] {S_RED, S_YELLOW, S_GREEN} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_red, r_yellow, r_green, r_busy;
    logic [CNT_W-1:0] w_red_load, w_yel_load;

    // divider only matters at load time, so it is folded into the load value
    assign w_red_load = (CNT_W'(RED_BASE) << i_divider) - CNT_W'(1);
    assign w_yel_load = (CNT_W'(YEL_BASE) << i_divider) - CNT_W'(1);

`ifdef SEMAFOR_BLINK_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    logic [BW-1:0] r_blk;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state  <= S_RED;
            r_cnt    <= CNT_W'(RED_BASE - 1);
            r_red    <= 1'b1;
            r_yellow <= 1'b0;
            r_green  <= 1'b0;
            r_busy   <= 1'b1;
`ifdef SEMAFOR_BLINK_EN
            r_blk    <= '0;
`endif
        end else if (i_train) begin
            r_state  <= S_RED;
            r_cnt    <= w_red_load;
            r_red    <= 1'b1;
            r_yellow <= 1'b0;
            r_green  <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            case (r_state)
                S_RED: begin
                    if (r_cnt == '0) begin
                        r_state  <= S_YELLOW;
                        r_cnt    <= w_yel_load;
                        r_red    <= 1'b0;
                        r_yellow <= 1'b1;
`ifdef SEMAFOR_BLINK_EN
                        r_blk    <= BW'(BLINK_HALF - 1);
`endif
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_YELLOW: begin
                    if (r_cnt == '0) begin
                        r_state  <= S_GREEN;
                        r_yellow <= 1'b0;
                        r_green  <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
`ifdef SEMAFOR_BLINK_EN
                        // lamp toggles only; phase timing stays on r_cnt
                        if (r_blk == '0) begin
                            r_yellow <= ~r_yellow;
                            r_blk    <= BW'(BLINK_HALF - 1);
                        end else begin
                            r_blk <= r_blk - BW'(1);
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_red    = r_red;
    assign o_yellow = r_yellow;
    assign o_green  = r_green;
    assign o_busy   = r_busy;
endmodule

module semafor_multi #(
    parameter int CHANNELS     = 4,
    parameter int DIV_W        = 2,
    parameter int BASE_TICKS   = 4,
    parameter int RED_UNITS    = 4,
    parameter int YELLOW_UNITS = 2,
    parameter int CNT_W        = 8,
    parameter int BLINK_HALF   = 2
) (
    input  logic           clk,
    input  logic           clr,
    semafor_multi_if.slave bus
);
    localparam int RED_BASE = RED_UNITS * BASE_TICKS;
    localparam int YEL_BASE = YELLOW_UNITS * BASE_TICKS;
    localparam int MAX_SH   = (1 << DIV_W) - 1;

    // elaboration-time sanity on the counter width and blink period
    if ((RED_BASE << MAX_SH) > (1 << CNT_W) || (YEL_BASE << MAX_SH) > (1 << CNT_W))
        $error("semafor_multi: CNT_W too narrow for the largest duration");
    if (BLINK_HALF < 1)
        $error("semafor_multi: BLINK_HALF must be at least 1");

    logic [CHANNELS-1:0] w_red, w_yellow, w_green, w_busy;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        semafor_lane #(
            .DIV_W      (DIV_W),
            .CNT_W      (CNT_W),
            .RED_BASE   (RED_BASE),
            .YEL_BASE   (YEL_BASE),
            .BLINK_HALF (BLINK_HALF)
        ) u_lane (
            .clk       (clk),
            .clr       (clr),
            .i_train   (bus.train[g]),
            .i_divider (bus.divider),
            .o_red     (w_red[g]),
            .o_yellow  (w_yellow[g]),
            .o_green   (w_green[g]),
            .o_busy    (w_busy[g])
        );
    end

    assign bus.red       = w_red;
    assign bus.yellow    = w_yellow;
    assign bus.green     = w_green;
    assign bus.busy      = w_busy;
    assign bus.all_green = &w_green;
endmodule
